// File: rtl/instruction_encoder_loader_pkg.sv
// instruction_encoder_loader_pkg: shared formats, states and immediate limits for the RV32I encoder/loader
package instruction_encoder_loader_pkg;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;
endpackage

// File: rtl/instruction_encoder_loader_inst_field_packer.sv
// inst_field_packer: packs RV32I fields and immediate into an instruction word and flags unrepresentable immediates
module inst_field_packer
  import instruction_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);
  logic signed [31:0] s;
  assign s = imm;
  always_comb begin
    inst = NOP_INST;
    err = 1'b1;
    case (fmt)
      FMT_R: begin
        inst = {funct7, rs2, rs1, funct3, rd, opcode};
        err = 1'b0;
      end
      FMT_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err = s < IMM12_MIN || s > IMM12_MAX;
      end
      FMT_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err = s < IMM12_MIN || s > IMM12_MAX;
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err = s < IMM13_MIN || s > IMM13_MAX || imm[0];
      end
      FMT_U: begin
        inst = {imm[31:12], rd, opcode};
        err = |imm[11:0];
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err = s < IMM21_MIN || s > IMM21_MAX || imm[0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader: encodes field bundles and streams them with sequential addresses to instruction memory
module instruction_encoder_loader
  import instruction_encoder_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt
);
  state_e state;
  logic [LEN_W-1:0] remaining;
  logic [ADDR_W-1:0] addr;
  logic [31:0] enc_inst;
  logic enc_err, accept;
  inst_field_packer u_packer (
    .fmt(in_fmt), .opcode(in_opcode), .funct3(in_funct3), .funct7(in_funct7),
    .rd(in_rd), .rs1(in_rs1), .rs2(in_rs2), .imm(in_imm),
    .inst(enc_inst), .err(enc_err)
  );
  // single output register refills in the same cycle it drains
  assign in_ready = state == LOAD && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      remaining <= '0;
      addr <= BASE_ADDR;
      out_valid <= 1'b0;
      out_inst <= '0;
      out_addr <= BASE_ADDR;
      out_err <= 1'b0;
      done <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        out_valid <= 1'b1;
        out_inst <= enc_inst;
        out_addr <= addr;
        out_err <= enc_err;
        addr <= addr + ADDR_W'(4);
        remaining <= remaining - LEN_W'(1);
        if (enc_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          if (prog_len != '0) begin
            state <= LOAD;
            remaining <= prog_len;
            addr <= BASE_ADDR;
            err_cnt <= '0;
          end else begin
            done <= 1'b1;
          end
        end
        LOAD: if (accept && remaining == LEN_W'(1)) state <= DRAIN;
        DRAIN: if (out_valid && out_ready) begin
          state <= IDLE;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_encoder_loader.sv
// tb_instruction_encoder_loader: scoreboard bench for the encoder/loader stream
module tb_instruction_encoder_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] prog_len = '0;
  logic [2:0] in_fmt = '0, in_funct3 = '0;
  logic [6:0] in_opcode = '0, in_funct7 = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic in_ready, out_valid, out_err, busy, done;
  logic [31:0] out_inst, out_addr;
  logic [7:0] err_cnt;
  typedef struct {logic [31:0] inst; logic [31:0] addr; logic err;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] nxt_addr = '0;
  int total = 0, bad = 0;

  instruction_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .busy(busy),
    .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && out_valid && out_ready) begin
    if (sb.size() == 0) chk("extra_word", 32'(out_valid), 32'd0);
    else begin
      e = sb.pop_front();
      chk("out_inst", out_inst, e.inst);
      chk("out_addr", out_addr, e.addr);
      chk("out_err", 32'(out_err), 32'(e.err));
    end
  end

  task automatic load(input logic [15:0] n);
    start = 1'b1;
    prog_len = n;
    nxt_addr = '0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] ei, input logic ee);
    int n = 0;
    in_valid = 1'b1;
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) chk("accept_wait", 32'(in_ready), 32'd1);
    else begin
      sb.push_back('{ei, nxt_addr, ee});
      nxt_addr += 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 40) begin n++; @(negedge clk); end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // basic I then R, done exactly one cycle after last handoff
    load(16'd2);
    chk("load_busy", 32'(busy), 32'd1);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    @(negedge clk);
    chk("early_done", 32'(done), 32'd0);
    wait_done("basic");
    chk("basic_err_cnt", 32'(err_cnt), 32'd0);
    // S, B, U
    load(16'd3);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    wait_done("sbu");
    // range error and illegal format
    load(16'd2);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, 1'b1);
    chk("err_cnt_1", 32'(err_cnt), 32'd1);
    send(3'd7, 7'h33, 3'd1, 7'd5, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0000_0013, 1'b1);
    chk("err_cnt_2", 32'(err_cnt), 32'd2);
    wait_done("err");
    // immediate boundaries
    load(16'd5);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047, 32'h7FF0_0093, 1'b0);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0020_8163, 1'b1);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
    wait_done("bound");
    chk("bound_err_cnt", 32'(err_cnt), 32'd2);
    // stall then continuous flow
    out_ready = 1'b0;
    load(16'd4);
    fork
      begin
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2, 32'h0020_0093, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 32'h0030_0093, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4, 32'h0040_0093, 1'b0);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin n++; @(negedge clk); end
        for (int i = 0; i < 3; i++) begin
          chk("stall_ready", 32'(in_ready), 32'd0);
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_inst", out_inst, 32'h0010_0093);
          chk("stall_addr", out_addr, 32'd0);
          if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("flow_valid", 32'(out_valid), 32'd1);
        end
      end
    join
    wait_done("flow");
    // zero-length load
    load(16'd0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zero_pulse", 32'(done), 32'd0);
    @(posedge clk); #1;
    // start during LOAD is ignored
    load(16'd2);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, 32'h0070_0113, 1'b0);
    start = 1'b1;
    prog_len = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    wait_done("restart");
    // reset mid-load drops the in-flight word
    out_ready = 1'b0;
    load(16'd3);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", out_addr, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    load(16'd1);
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    wait_done("after_rst");
    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_encoder_loader.md
Name: instruction_encoder_loader

Overview:
- Inverse of the instruction field decoder: takes RV32I instruction fields plus an immediate and packs them into a 32-bit instruction word in R/I/S/B/U/J format.
- Streams the encoded words, each tagged with a sequential byte address, to the instruction-memory write port.
- Used by the test harness and boot loader to load a program of known length into instruction memory.
- Has a load FSM, a registered valid/ready output stage, an address counter and an immediate-range error check.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- BASE_ADDR, 32'h0000_0000, address of the first word written. Must be 4-byte aligned.
- LEN_W, 16, width of the program-length field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load. Sampled only in IDLE.
- prog_len  in  LEN_W  number of instructions to load, sampled with start.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_fmt  in  3  format: R=0, I=1, S=2, B=3, U=4, J=5. Values 6 and 7 are illegal.
- in_opcode  in  7.
- in_funct3  in  3.
- in_funct7  in  7.
- in_rd  in  5.
- in_rs1  in  5.
- in_rs2  in  5.
- in_imm  in  32  signed byte immediate. For U format this is the full value, with the upper 20 bits used.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  memory accepts the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_inst.
- out_err  out  1  immediate not representable, or illegal format.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when the load completes.
- err_cnt  out  8  saturating count of words with out_err set in the current load.

Behaviour:
- Reset values:
  - out_valid=0, out_inst=0, out_addr=BASE_ADDR, out_err=0.
  - busy=0, done=0, err_cnt=0, in_ready=0.
  - FSM state is IDLE, remaining count is 0.
- FSM states: IDLE, LOAD, DRAIN.
- IDLE:
  - in_ready=0.
  - start with prog_len>0: go to LOAD; remaining=prog_len; next address=BASE_ADDR; err_cnt=0.
  - start with prog_len=0: pulse done the next cycle and stay in IDLE.
- LOAD:
  - in_ready = !out_valid || out_ready (single output register, no bubble under continuous flow).
  - Accept happens on in_valid && in_ready. On accept:
    - register the encoded word, the address and the error flag;
    - address += 4 (wraps modulo 2^ADDR_W);
    - remaining -= 1;
    - err_cnt += out_err, saturating at 255.
  - When the accepted bundle is the last one (remaining==1): go to DRAIN.
- DRAIN:
  - in_ready=0.
  - Once the last word is handed off (out_valid && out_ready): done=1 for 1 cycle, then IDLE.
- Output stage:
  - Latency from accept to out_valid is 1 cycle.
  - While out_valid && !out_ready, out_inst, out_addr and out_err hold stable.
  - out_valid clears when the word is taken and no new accept happens in the same cycle.
- start outside IDLE is ignored. in_valid in IDLE or DRAIN is ignored and not consumed.
- Encoding (imm bit slices; fields as named):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - U: imm[31:12] | rd | opcode.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
- Range check; out_err=1 when:
  - I or S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - J: imm outside [-2^20, 2^20-2], or imm[0]=1.
  - U: imm[11:0]≠0.
  - R: never.
- On a range error the word is still encoded from the truncated bits.
- Illegal format (6, 7): out_inst=32'h0000_0013 (NOP), out_err=1.
- Reset asserted mid-load: everything returns immediately to its reset values. The in-flight word is dropped and done is not pulsed.

Decomposition:
- Shared package entries:
  - format enum fmt_e (FMT_R..FMT_J);
  - NOP_INST constant;
  - immediate limit constants.
- Opcode constants come from the existing constants file.
- One natural combinational sub-module, inst_field_packer: fmt plus fields plus imm → inst and err.
- The top level holds the FSM, counters and output register.

Test Plan:
- start, prog_len=2, BASE_ADDR=0, out_ready=1; send I(op=0x13, rd=1, rs1=0, f3=0, imm=5), then R(op=0x33, rd=3, rs1=1, rs2=2) → words 0x00500093@0x0 and 0x002081B3@0x4; done pulses 1 cycle after the second handoff; err_cnt=0.
- S(op=0x23, f3=2, rs1=1, rs2=2, imm=8) → 0x0020A423. B(op=0x63, f3=0, rs1=1, rs2=2, imm=-4) → 0xFE208EE3. U(op=0x37, rd=5, imm=0x12345000) → 0x123452B7.
- I with imm=2048 → out_err=1, out_inst[31:20]=0x800, err_cnt=1. Format 7 → out_inst=0x00000013, out_err=1.
- Back-to-back inputs with out_ready=0 for 3 cycles → in_ready=0 and out_* held constant; on release, a new word every cycle with no loss or duplication.
- start with prog_len=0 → done pulse, busy stays 0. start asserted while in LOAD → ignored, remaining unchanged.
- rst_n pulled low mid-load after 1 of 3 words → out_valid=0, busy=0, out_addr=BASE_ADDR, no done; a new start then loads correctly from BASE_ADDR.
